// File: rtl/timer_sequencer.sv
// Countdown timer sequencer: previews the selected mode's duration while idle,
// counts down in BCD MM:SS once per tick while running, and pulses timerEnd
// on natural completion.
module timer_sequencer #(
   parameter int unsigned TICK_DIV  = 100_000_000,
   parameter int unsigned MODE0_MIN = 1,
   parameter int unsigned MODE1_MIN = 5,
   parameter int unsigned MODE2_MIN = 10,
   parameter int unsigned MODE3_MIN = 25
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  mode,
   input  logic        start,
   output logic        timerEnd,
   output logic        running,
   output logic [15:0] digits
);

   localparam int unsigned PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] TickLast = PW'(TICK_DIV - 1);

   // MM:00 preview words, resolved at elaboration so no runtime divider is needed
   localparam logic [15:0] Preview0 = {4'(MODE0_MIN / 10), 4'(MODE0_MIN % 10), 8'h00};
   localparam logic [15:0] Preview1 = {4'(MODE1_MIN / 10), 4'(MODE1_MIN % 10), 8'h00};
   localparam logic [15:0] Preview2 = {4'(MODE2_MIN / 10), 4'(MODE2_MIN % 10), 8'h00};
   localparam logic [15:0] Preview3 = {4'(MODE3_MIN / 10), 4'(MODE3_MIN % 10), 8'h00};

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [15:0]   digits_q, digits_d;
   logic          start_q;
   logic          timer_end_q, timer_end_d;
   logic          running_q, running_d;
   logic [15:0]   preview;

   // Subtract one second from a BCD MM:SS value, borrowing through each digit
   function automatic logic [15:0] bcd_dec(input logic [15:0] d);
      logic [3:0] mt, mo, st, so;
      {mt, mo, st, so} = d;
      if (so != 4'd0) begin
         so = so - 4'd1;
      end else begin
         so = 4'd9;
         if (st != 4'd0) begin
            st = st - 4'd1;
         end else begin
            st = 4'd5;
            if (mo != 4'd0) begin
               mo = mo - 4'd1;
            end else begin
               mo = 4'd9;
               mt = mt - 4'd1;
            end
         end
      end
      return {mt, mo, st, so};
   endfunction

   // Select the preview word for the currently sampled mode
   always_comb begin
      case (mode)
         2'd0:    preview = Preview0;
         2'd1:    preview = Preview1;
         2'd2:    preview = Preview2;
         default: preview = Preview3;
      endcase
   end

   // Next-state logic; abort on start=0 wins over a coincident tick
   always_comb begin
      state_d     = state_q;
      presc_d     = presc_q;
      digits_d    = digits_q;
      timer_end_d = 1'b0;
      case (state_q)
         StIdle: begin
            // Entering RUN loads the same preview, which latches the duration
            digits_d = preview;
            presc_d  = '0;
            if (start && !start_q) begin
               state_d = StRun;
            end
         end
         StRun: begin
            if (!start) begin
               state_d = StIdle;
               presc_d = '0;
            end else if (presc_q == TickLast) begin
               presc_d  = '0;
               digits_d = bcd_dec(digits_q);
               if (digits_d == 16'h0000) begin
                  state_d     = StDone;
                  timer_end_d = 1'b1;
               end
            end else begin
               presc_d = presc_q + PW'(1);
            end
         end
         StDone: begin
            state_d  = StIdle;
            digits_d = 16'h0000;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      running_d = (state_d == StRun);
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= StIdle;
         presc_q     <= '0;
         digits_q    <= 16'h0000;
         start_q     <= 1'b0;
         timer_end_q <= 1'b0;
         running_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         presc_q     <= presc_d;
         digits_q    <= digits_d;
         start_q     <= start;
         timer_end_q <= timer_end_d;
         running_q   <= running_d;
      end
   end

   assign timerEnd = timer_end_q;
   assign running  = running_q;
   assign digits   = digits_q;

endmodule
